mul_div_unit: RTL and testbench
===============================

# mul_div_unit

Iterative RV32M multiply/divide unit that sits in the execute stage beside the single-cycle ALU. It takes the same two 32-bit operands and returns a 32-bit result to the same writeback path. Because each operation takes multiple cycles, the unit uses a valid/ready start handshake, a one-cycle `done` pulse, and a flush input. The pipeline stalls on `busy`.

## Interface
Parameters:
- none; the data width is fixed at 32.

Ports:
- `clk`  in  1  — the single clock.
- `reset_n`  in  1  — asynchronous, active-low reset.
- `valid_in`  in  1  — an operation is offered this cycle.
- `ready`  out  1  — the unit can accept an operation this cycle.
- `op`  in  3  — `md_op_t` operation code; sampled on accept.
- `left_operand`  in  32  — rs1 value; sampled on accept.
- `right_operand`  in  32  — rs2 value; sampled on accept.
- `flush`  in  1  — abort any in-flight operation.
- `busy`  out  1  — an operation is in flight (state BUSY).
- `done`  out  1  — one-cycle pulse; `result` is valid in this cycle.
- `result`  out  32  — the operation result; held until the next accept.

## Operation
- State machine `md_state_t` with states IDLE, BUSY and DONE.
- `ready` = (state == IDLE) || (state == DONE), so back-to-back operations are allowed.
- Accept = `valid_in` && `ready` && !`flush`. On accept:
  - latch `op` and both operands;
  - compute the operand signs and absolute values;
  - load the iteration counter with 31.
- Multiply ops: MUL, MULH, MULHSU, MULHU.
  - Shift-add on the unsigned magnitudes into a 64-bit product, one bit per cycle.
  - Negate the product at the end if the sign requires it.
  - Operand signedness: MULH treats both operands as signed; MULHSU treats left as signed, right as unsigned; MULHU treats both as unsigned.
  - MUL returns product[31:0]; the MULH variants return product[63:32].
- Divide ops: DIV, DIVU, REM, REMU.
  - Restoring division on the magnitudes, one quotient bit per cycle.
  - Quotient sign = sign(left) XOR sign(right). Remainder sign = sign(left).
- Fast path: on accept, go straight to DONE (no BUSY cycles) for these cases:
  - Divide by zero: DIV/DIVU return 0xFFFF_FFFF; REM/REMU return left_operand.
  - Signed overflow (left = 0x8000_0000, right = 0xFFFF_FFFF): DIV returns 0x8000_0000; REM returns 0.
- Transitions:
  - IDLE → BUSY on accept (normal path).
  - IDLE → DONE on accept (fast path).
  - BUSY → BUSY while counter != 0; the counter decrements each cycle.
  - BUSY → DONE after the iteration in which counter == 0.
  - DONE → BUSY or DONE on accept; otherwise DONE → IDLE.
- `flush`:
  - In any state, the next state is IDLE, with no `done` pulse and `result` unchanged.
  - `flush` dominates a simultaneous `valid_in`.
- Reset values:
  - state IDLE, counter 0, `result` 0;
  - `busy` 0, `done` 0, `ready` 1.
- Width rules:
  - Internal accumulators are 64-bit for multiply.
  - The remainder register is 33-bit for divide, so the trial subtraction keeps its borrow bit.
  - All negation is two's complement modulo 2^32 or 2^64.

## Timing
- Accept is sampled on the rising edge at the end of cycle T.
- Normal path:
  - `busy` = 1 in cycles T+1 through T+32.
  - `done` = 1 and `result` is valid in cycle T+33.
  - Latency is 33 cycles.
- Fast path: `done` = 1 in cycle T+1, with `busy` never asserted.
- `done` is high for exactly one cycle per completed operation.
- `result` is registered and changes only on entry to DONE.
- An accept during DONE starts the new operation. The current `done` pulse still completes in that cycle.
- Deasserting `reset_n` at any time forces the reset values immediately (asynchronously). Nothing completes afterwards.
- Operand or `op` changes after accept have no effect.

## Structure
- Shared package `common`:
  - `md_op_t` (3-bit enum): MD_MUL, MD_MULH, MD_MULHSU, MD_MULHU, MD_DIV, MD_DIVU, MD_REM, MD_REMU, encoded as funct3.
  - `md_state_t`.
  - The constant `MD_ITERATIONS = 32`.
- Single module, no sub-module. The shift-add and restoring datapaths share the counter and the operand registers.

## Test plan
- MUL 7 × −3 (0x0000_0007, 0xFFFF_FFFD) → `result` = 0xFFFF_FFEB; `done` in cycle T+33; `busy` high for exactly 32 cycles.
- MULH / MULHSU / MULHU with 0x8000_0000 × 0xFFFF_FFFF → 0x0000_0000, 0x8000_0000 and 0x7FFF_FFFF respectively.
- DIV −7 / 2 → 0xFFFF_FFFD; REM −7 / 2 → 0xFFFF_FFFF; DIVU 100 / 7 → 14; REMU 100 / 7 → 2.
- DIVU 5 / 0 → 0xFFFF_FFFF and REM 5 / 0 → 5, each with `done` at T+1. DIV 0x8000_0000 / −1 → 0x8000_0000 with `done` at T+1.
- Flush at T+10 of a DIV → IDLE at T+11, no `done` pulse, `result` holds its previous value. Then `reset_n` low mid-BUSY → `ready` = 1 and `busy` = 0 immediately.
- Back-to-back: offer a second MUL in the DONE cycle of the first → both `done` pulses present 33 cycles apart, with the correct results.

Source files
------------

// File: rtl/common_pkg.sv
// Shared types and constants for the RV32M multiply/divide unit.
package common;

    typedef enum logic [2:0] {
        MD_MUL    = 3'b000,
        MD_MULH   = 3'b001,
        MD_MULHSU = 3'b010,
        MD_MULHU  = 3'b011,
        MD_DIV    = 3'b100,
        MD_DIVU   = 3'b101,
        MD_REM    = 3'b110,
        MD_REMU   = 3'b111
    } md_op_t;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        BUSY = 2'b01,
        DONE = 2'b10
    } md_state_t;

    localparam int MD_ITERATIONS = 32;

endpackage

// File: rtl/mul_div_unit.sv
// Iterative RV32M multiply/divide: shift-add multiply and restoring divide on
// operand magnitudes, one bit per cycle, with sign fix-up on completion.
module mul_div_unit
    import common::*;
(
    input  logic        clk,
    input  logic        reset_n,
    input  logic        valid_in,
    output logic        ready,
    input  md_op_t      op,
    input  logic [31:0] left_operand,
    input  logic [31:0] right_operand,
    input  logic        flush,
    output logic        busy,
    output logic        done,
    output logic [31:0] result,
    output md_state_t   state_dbg
);

    // Handshake: an operation is accepted on a rising edge where valid_in and
    // ready are both high and flush is low; flush always wins over valid_in.

    md_state_t   r_state;
    md_op_t      r_op;
    logic [4:0]  r_count;
    logic [63:0] r_acc;
    logic [31:0] r_b;
    logic [32:0] r_rem;
    logic        r_neg;
    logic        r_neg_rem;
    logic [31:0] r_result;
    logic        r_busy;
    logic        r_done;
    logic        r_ready;

    logic        w_accept;
    logic        w_a_signed;
    logic        w_b_signed;
    logic        w_sa;
    logic        w_sb;
    logic        w_div_zero;
    logic        w_overflow;
    logic        w_fast;
    logic [31:0] w_mag_a;
    logic [31:0] w_mag_b;
    logic [31:0] w_fast_result;

    logic [32:0] w_sum;
    logic [63:0] w_prod_next;
    logic [33:0] w_shift;
    logic [33:0] w_diff;
    logic        w_borrow;
    logic [32:0] w_rem_next;
    logic [31:0] w_quot_next;
    logic [63:0] w_acc_next;
    logic [63:0] w_prod_fix;
    logic [31:0] w_quot_fix;
    logic [31:0] w_rem_fix;
    logic [31:0] w_final;

    assign w_accept = valid_in && r_ready && !flush;

    always_comb begin
        w_a_signed = (op == MD_MUL) || (op == MD_MULH) || (op == MD_MULHSU) ||
                     (op == MD_DIV) || (op == MD_REM);
        w_b_signed = (op == MD_MUL) || (op == MD_MULH) ||
                     (op == MD_DIV) || (op == MD_REM);
        w_sa       = w_a_signed && left_operand[31];
        w_sb       = w_b_signed && right_operand[31];
        w_mag_a    = w_sa ? -left_operand  : left_operand;
        w_mag_b    = w_sb ? -right_operand : right_operand;
        w_div_zero = op[2] && (right_operand == 32'd0);
        w_overflow = ((op == MD_DIV) || (op == MD_REM)) &&
                     (left_operand == 32'h8000_0000) && (right_operand == 32'hFFFF_FFFF);
        w_fast     = w_div_zero || w_overflow;
        // op[1] separates the remainder ops from the quotient ops.
        if (w_div_zero) begin
            w_fast_result = op[1] ? left_operand : 32'hFFFF_FFFF;
        end else begin
            w_fast_result = op[1] ? 32'd0 : 32'h8000_0000;
        end
    end

    always_comb begin
        w_sum       = {1'b0, r_acc[63:32]} + (r_acc[0] ? {1'b0, r_b} : 33'd0);
        w_prod_next = {w_sum, r_acc[31:1]};
        w_shift     = {r_rem, r_acc[31]};
        w_diff      = w_shift - {2'b00, r_b};
        w_borrow    = w_diff[33];
        w_rem_next  = w_borrow ? w_shift[32:0] : w_diff[32:0];
        w_quot_next = {r_acc[30:0], ~w_borrow};
        w_acc_next  = r_op[2] ? {32'd0, w_quot_next} : w_prod_next;
        w_prod_fix  = r_neg ? -w_prod_next : w_prod_next;
        w_quot_fix  = r_neg ? -w_quot_next : w_quot_next;
        w_rem_fix   = r_neg_rem ? -w_rem_next[31:0] : w_rem_next[31:0];
        case (r_op)
            MD_MUL:                      w_final = w_prod_fix[31:0];
            MD_MULH, MD_MULHSU, MD_MULHU: w_final = w_prod_fix[63:32];
            MD_DIV, MD_DIVU:             w_final = w_quot_fix;
            default:                     w_final = w_rem_fix;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state   <= IDLE;
            r_op      <= MD_MUL;
            r_count   <= '0;
            r_acc     <= '0;
            r_b       <= '0;
            r_rem     <= '0;
            r_neg     <= 1'b0;
            r_neg_rem <= 1'b0;
            r_result  <= '0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_ready   <= 1'b1;
        end else if (flush) begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_ready <= 1'b1;
        end else if (w_accept) begin
            r_op      <= op;
            r_neg     <= w_sa ^ w_sb;
            r_neg_rem <= w_sa;
            r_acc     <= {32'd0, w_mag_a};
            r_b       <= w_mag_b;
            r_rem     <= '0;
            r_count   <= 5'(MD_ITERATIONS - 1);
            if (w_fast) begin
                r_result <= w_fast_result;
                r_state  <= DONE;
                r_done   <= 1'b1;
                r_busy   <= 1'b0;
                r_ready  <= 1'b1;
            end else begin
                r_state <= BUSY;
                r_done  <= 1'b0;
                r_busy  <= 1'b1;
                r_ready <= 1'b0;
            end
        end else begin
            case (r_state)
                BUSY: begin
                    r_acc <= w_acc_next;
                    r_rem <= w_rem_next;
                    // The last iteration's result is registered straight into r_result.
                    if (r_count == 5'd0) begin
                        r_result <= w_final;
                        r_state  <= DONE;
                        r_done   <= 1'b1;
                        r_busy   <= 1'b0;
                        r_ready  <= 1'b1;
                    end else begin
                        r_count <= r_count - 5'd1;
                    end
                end
                DONE: begin
                    r_state <= IDLE;
                    r_done  <= 1'b0;
                end
                default: r_done <= 1'b0;
            endcase
        end
    end

    assign ready     = r_ready;
    assign busy      = r_busy;
    assign done      = r_done;
    assign result    = r_result;
    assign state_dbg = r_state;

endmodule

// File: tb/tb_mul_div_unit.sv
// Bench for mul_div_unit: directed cases plus random operations checked against
// an arithmetic reference model of the RV32M multiply/divide rules.
module tb_mul_div_unit;
    import common::*;

    logic        clk;
    logic        reset_n;
    logic        valid_in;
    logic        ready;
    md_op_t      op;
    logic [31:0] left_operand;
    logic [31:0] right_operand;
    logic        flush;
    logic        busy;
    logic        done;
    logic [31:0] result;
    md_state_t   state_dbg;

    int tests;
    int fails;

    mul_div_unit dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .valid_in     (valid_in),
        .ready        (ready),
        .op           (op),
        .left_operand (left_operand),
        .right_operand(right_operand),
        .flush        (flush),
        .busy         (busy),
        .done         (done),
        .result       (result),
        .state_dbg    (state_dbg)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] ref_md(input md_op_t o, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] sa, sb, ua, ub, p;
        int ia, ib;
        sa = {{32{a[31]}}, a};
        sb = {{32{b[31]}}, b};
        ua = {32'd0, a};
        ub = {32'd0, b};
        ia = a;
        ib = b;
        case (o)
            MD_MUL:    begin p = sa * sb; return p[31:0];  end
            MD_MULH:   begin p = sa * sb; return p[63:32]; end
            MD_MULHSU: begin p = sa * ub; return p[63:32]; end
            MD_MULHU:  begin p = ua * ub; return p[63:32]; end
            MD_DIV: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
                return ia / ib;
            end
            MD_DIVU:   return (b == 0) ? 32'hFFFF_FFFF : a / b;
            MD_REM: begin
                if (b == 0) return a;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
                return ia % ib;
            end
            default:   return (b == 0) ? a : a % b;
        endcase
    endfunction

    function automatic int ref_latency(input md_op_t o, input logic [31:0] a, input logic [31:0] b);
        if (o inside {MD_DIV, MD_DIVU, MD_REM, MD_REMU} && b == 0) return 1;
        if (o inside {MD_DIV, MD_REM} && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
        return 33;
    endfunction

    // Called just after a falling edge; returns just after the accepting rising edge.
    task automatic start_op(input md_op_t o, input logic [31:0] a, input logic [31:0] b);
        valid_in      = 1'b1;
        op            = o;
        left_operand  = a;
        right_operand = b;
        @(posedge clk);
        #1;
        valid_in      = 1'b0;
        op            = md_op_t'(3'($urandom_range(0, 7)));
        left_operand  = $urandom;
        right_operand = $urandom;
    endtask

    // Returns at the falling edge inside the done cycle (or after the time budget).
    task automatic wait_done(input string tag, input int exp_lat, input logic [31:0] exp_res);
        int k;
        int busy_cnt;
        int ready_bad;
        bit seen;
        k = 0; busy_cnt = 0; ready_bad = 0; seen = 1'b0;
        while (!seen && k < 40) begin
            @(negedge clk);
            k++;
            if (busy) busy_cnt++;
            if (busy && ready) ready_bad++;
            if (done) seen = 1'b1;
        end
        check({tag, "_latency"}, 32'(k), 32'(exp_lat));
        check({tag, "_busy_cycles"}, 32'(busy_cnt), 32'(exp_lat - 1));
        check({tag, "_result"}, result, exp_res);
        if (exp_lat > 1) check({tag, "_ready_low_while_busy"}, 32'(ready_bad), 32'd0);
    endtask

    task automatic expect_idle_next(input string tag);
        @(negedge clk);
        check({tag, "_done_single_pulse"}, {31'd0, done}, 32'd0);
        check({tag, "_ready_after"}, {31'd0, ready}, 32'd1);
    endtask

    task automatic run_op(input string tag, input md_op_t o, input logic [31:0] a, input logic [31:0] b);
        start_op(o, a, b);
        wait_done(tag, ref_latency(o, a, b), ref_md(o, a, b));
        expect_idle_next(tag);
    endtask

    function automatic logic [31:0] pick_operand();
        case ($urandom_range(0, 7))
            0: return 32'd0;
            1: return 32'd1;
            2: return 32'hFFFF_FFFF;
            3: return 32'h8000_0000;
            4: return 32'($urandom_range(0, 100));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        logic [31:0] prev;
        int pulses;
        md_op_t ro;
        logic [31:0] ra, rb;

        tests = 0; fails = 0;
        reset_n = 1'b0; valid_in = 1'b0; flush = 1'b0;
        op = MD_MUL; left_operand = '0; right_operand = '0;
        repeat (2) @(negedge clk);
        check("reset_ready", {31'd0, ready}, 32'd1);
        check("reset_busy", {31'd0, busy}, 32'd0);
        check("reset_done", {31'd0, done}, 32'd0);
        check("reset_result", result, 32'd0);
        check("reset_state", {30'd0, state_dbg}, {30'd0, IDLE});
        reset_n = 1'b1;
        @(negedge clk);

        run_op("mul_7_m3", MD_MUL, 32'd7, 32'hFFFF_FFFD);
        check("mul_7_m3_const", result, 32'hFFFF_FFEB);
        run_op("mulh_min", MD_MULH, 32'h8000_0000, 32'hFFFF_FFFF);
        check("mulh_min_const", result, 32'h0000_0000);
        run_op("mulhsu_min", MD_MULHSU, 32'h8000_0000, 32'hFFFF_FFFF);
        check("mulhsu_min_const", result, 32'h8000_0000);
        run_op("mulhu_min", MD_MULHU, 32'h8000_0000, 32'hFFFF_FFFF);
        check("mulhu_min_const", result, 32'h7FFF_FFFF);
        run_op("div_m7_2", MD_DIV, 32'hFFFF_FFF9, 32'd2);
        check("div_m7_2_const", result, 32'hFFFF_FFFD);
        run_op("rem_m7_2", MD_REM, 32'hFFFF_FFF9, 32'd2);
        check("rem_m7_2_const", result, 32'hFFFF_FFFF);
        run_op("divu_100_7", MD_DIVU, 32'd100, 32'd7);
        check("divu_100_7_const", result, 32'd14);
        run_op("remu_100_7", MD_REMU, 32'd100, 32'd7);
        check("remu_100_7_const", result, 32'd2);
        run_op("divu_by0", MD_DIVU, 32'd5, 32'd0);
        check("divu_by0_const", result, 32'hFFFF_FFFF);
        run_op("rem_by0", MD_REM, 32'd5, 32'd0);
        check("rem_by0_const", result, 32'd5);
        run_op("div_ovf", MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
        check("div_ovf_const", result, 32'h8000_0000);
        run_op("rem_ovf", MD_REM, 32'h8000_0000, 32'hFFFF_FFFF);

        // Back-to-back: second MUL offered in the done cycle of the first.
        start_op(MD_MUL, 32'd1234, 32'd5678);
        wait_done("b2b_first", 33, 32'd7006652);
        check("b2b_ready_in_done", {31'd0, ready}, 32'd1);
        start_op(MD_MUL, 32'hFFFF_FF00, 32'd300);
        wait_done("b2b_second", 33, ref_md(MD_MUL, 32'hFFFF_FF00, 32'd300));
        expect_idle_next("b2b_second");

        // Flush a divide at T+10: idle at T+11, no done, result held.
        prev = result;
        start_op(MD_DIV, 32'd1000, 32'd3);
        repeat (10) @(negedge clk);
        flush = 1'b1;
        @(posedge clk);
        #1 flush = 1'b0;
        @(negedge clk);
        check("flush_busy", {31'd0, busy}, 32'd0);
        check("flush_ready", {31'd0, ready}, 32'd1);
        check("flush_done", {31'd0, done}, 32'd0);
        check("flush_result_held", result, prev);
        pulses = 0;
        repeat (40) begin
            @(negedge clk);
            if (done) pulses++;
        end
        check("flush_no_done", 32'(pulses), 32'd0);
        check("flush_result_still", result, prev);

        // Flush dominates a simultaneous valid_in, even for a fast-path op.
        valid_in = 1'b1; flush = 1'b1;
        op = MD_DIVU; left_operand = 32'd9; right_operand = 32'd0;
        @(posedge clk);
        #1 valid_in = 1'b0; flush = 1'b0;
        @(negedge clk);
        check("flush_dom_done", {31'd0, done}, 32'd0);
        check("flush_dom_busy", {31'd0, busy}, 32'd0);
        check("flush_dom_result", result, prev);

        // Asynchronous reset in the middle of a multiply.
        start_op(MD_MUL, 32'd99, 32'd77);
        repeat (5) @(negedge clk);
        reset_n = 1'b0;
        #1;
        check("areset_ready", {31'd0, ready}, 32'd1);
        check("areset_busy", {31'd0, busy}, 32'd0);
        check("areset_result", result, 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        pulses = 0;
        repeat (40) begin
            @(negedge clk);
            if (done) pulses++;
        end
        check("areset_no_done", 32'(pulses), 32'd0);

        // Random operations against the reference model.
        for (int i = 0; i < 30; i++) begin
            ro = md_op_t'(3'($urandom_range(0, 7)));
            ra = pick_operand();
            rb = pick_operand();
            run_op($sformatf("rand%0d_op%0d", i, ro), ro, ra, rb);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
